instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 resetn  input  1  reset; one clock; reset is synchronous and active-low.
REQ-004 imem_req_valid  output  1  fetch request to instruction memory.
REQ-005 imem_req_addr  output  32  word-aligned fetch address; bits [1:0] always 2'b00.
REQ-006 imem_req_ready  input  1  memory accepts request when high with imem_req_valid.
REQ-007 imem_resp_valid  input  1  response data valid this cycle.
REQ-008 imem_resp_data  input  32  fetched instruction word.
REQ-009 instr_valid  output  1  held instruction available to decode.
REQ-010 instr  output  32  instruction word; bits [31:26] drive the decoder opcode input.
REQ-011 instr_pc  output  32  address of instr.
REQ-012 instr_ready  input  1  decode consumes instr when high with instr_valid.
REQ-013 redirect_valid  input  1  taken branch or jump from decode/execute.
REQ-014 redirect_pc  input  32  redirect target; bits [1:0] ignored.

Function
REQ-015 FSM states SHALL be REQ, WAIT, HOLD, DROP; exactly one outstanding memory request at any time.
REQ-016 REQ: imem_req_valid=1, imem_req_addr=pc; on imem_req_ready -> WAIT, else stay REQ.
REQ-017 WAIT: on imem_resp_valid, capture data into instr and pc into instr_pc, pc <= pc+4 (mod 2^32, wrap at 32'hFFFF_FFFC to 0), -> HOLD.
REQ-018 HOLD: instr_valid=1; instr and instr_pc stable; on instr_ready -> REQ next cycle.
REQ-019 Latency: instr_valid asserts the cycle after imem_resp_valid; minimum 3 cycles per instruction with zero-wait memory.
REQ-020 Redirect has priority over all other events in the same cycle; pc <= {redirect_pc[31:2],2'b00}.
REQ-021 Redirect in REQ (accepted or not that cycle): if request was accepted same cycle -> DROP, else stay REQ with new address next cycle; a non-accepted request's address MAY change only due to redirect.
REQ-022 Redirect in WAIT without resp -> DROP; with resp same cycle -> response discarded, -> REQ.
REQ-023 Redirect in HOLD -> held instruction discarded (instr_valid=0 next cycle, even if instr_ready was high same cycle), -> REQ.
REQ-024 DROP: instr_valid=0; next imem_resp_valid discarded, -> REQ; redirect while in DROP updates pc, stays DROP unless resp same cycle (then -> REQ).
REQ-025 imem_resp_valid outside WAIT/DROP SHALL be ignored.
REQ-026 instr_valid SHALL be 0 in all states except HOLD.

Reset
REQ-027 While resetn=0 at a clock edge: state <= REQ, pc <= RESET_PC, instr <= 0, instr_pc <= 0.
REQ-028 Outputs after reset: imem_req_valid=1, imem_req_addr=RESET_PC, instr_valid=0.
REQ-029 Reset mid-transaction abandons it; an in-flight response arriving after reset release in REQ SHALL be ignored.

Structure
REQ-030 Shared package (common) SHALL hold u32 typedef, fetch_state_t enum (REQ, WAIT, HOLD, DROP) and INSTR_BYTES=4 constant.
REQ-031 One sub-module pc_next: combinational next-pc select (pc+4 / redirect, alignment masking); FSM and registers stay in instr_fetch.

Verification
REQ-032 Reset, zero-wait memory returning 32'h8C01_0004 (LW) at 0 -> instr_valid cycle 3 with instr=32'h8C01_0004, instr_pc=0; next imem_req_addr=4.
REQ-033 imem_req_ready low 5 cycles -> imem_req_valid/addr held stable, no state advance, fetch completes after ready.
REQ-034 instr_ready low 4 cycles in HOLD -> instr/instr_pc unchanged, no new request issued.
REQ-035 redirect_valid with redirect_pc=32'h0000_0103 while in WAIT -> next response dropped, next request addr=32'h0000_0100, no instr_valid for dropped word.
REQ-036 redirect and instr_ready same cycle in HOLD -> held word not re-presented, next request at redirect target.
REQ-037 pc at 32'hFFFF_FFFC fetch -> next imem_req_addr=32'h0000_0000; resetn low during WAIT -> next addr=RESET_PC, late response ignored.

Source files
------------

// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package instr_fetch_pkg;

    typedef logic [31:0] u32;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2,
        DROP = 2'd3
    } fetch_state_t;

    localparam u32 INSTR_BYTES = 32'd4;

    // Force an address onto a word boundary.
    function automatic u32 align_word(input u32 addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/instr_fetch_pc_next.sv
// Next fetch-address select: redirect target (word aligned), sequential
// increment, or hold. Redirect always wins.
module pc_next
    import instr_fetch_pkg::*;
(
    input  logic [31:0] pc,
    input  logic        advance,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] pc_nxt
);

    // Choose the next fetch address; the increment wraps naturally at 2^32.
    always_comb begin
        pc_nxt = pc;
        if (redirect_valid) begin
            pc_nxt = align_word(redirect_pc);
        end else if (advance) begin
            pc_nxt = pc + INSTR_BYTES;
        end else begin
            pc_nxt = pc;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Single-outstanding instruction fetch unit: issues one word request,
// waits for its response, holds the word for decode, and handles
// redirects by discarding whatever is in flight or held.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        resetn,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);

    fetch_state_t state_r;
    fetch_state_t state_nxt_s;
    u32           pc_r;
    u32           pc_nxt_s;
    logic         capture_s;

    // The request address is the fetch pc register itself.
    assign imem_req_addr = pc_r;

    pc_next u_pc_next (
        .pc             (pc_r),
        .advance        (capture_s),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .pc_nxt         (pc_nxt_s)
    );

    // Next-state decision; redirect takes priority over every other event.
    always_comb begin
        state_nxt_s = state_r;
        capture_s   = 1'b0;
        case (state_r)
            REQ: begin
                if (redirect_valid) begin
                    // An accepted request is now stale: its response must be dropped.
                    state_nxt_s = imem_req_ready ? DROP : REQ;
                end else if (imem_req_ready) begin
                    state_nxt_s = WAIT;
                end else begin
                    state_nxt_s = REQ;
                end
            end
            WAIT: begin
                if (redirect_valid) begin
                    state_nxt_s = imem_resp_valid ? REQ : DROP;
                end else if (imem_resp_valid) begin
                    state_nxt_s = HOLD;
                    capture_s   = 1'b1;
                end else begin
                    state_nxt_s = WAIT;
                end
            end
            HOLD: begin
                if (redirect_valid || instr_ready) begin
                    state_nxt_s = REQ;
                end else begin
                    state_nxt_s = HOLD;
                end
            end
            DROP: begin
                if (imem_resp_valid) begin
                    state_nxt_s = REQ;
                end else begin
                    state_nxt_s = DROP;
                end
            end
            default: begin
                state_nxt_s = REQ;
            end
        endcase
    end

    // State, pc, held instruction and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r        <= REQ;
            pc_r           <= align_word(RESET_PC);
            instr          <= 32'h0000_0000;
            instr_pc       <= 32'h0000_0000;
            imem_req_valid <= 1'b1;
            instr_valid    <= 1'b0;
        end else begin
            state_r        <= state_nxt_s;
            pc_r           <= pc_nxt_s;
            imem_req_valid <= (state_nxt_s == REQ);
            instr_valid    <= (state_nxt_s == HOLD);
            if (capture_s) begin
                instr    <= imem_resp_data;
                instr_pc <= pc_r;
            end else begin
                instr    <= instr;
                instr_pc <= instr_pc;
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: a transaction-level model (outstanding / discard /
// held flags) predicts outputs each cycle; directed scenarios add literal pins.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready = 1'b0;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = 32'h0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    // Memory responder state.
    bit          pend = 1'b0;
    logic [31:0] paddr = 32'h0;
    int          dly = 0;
    int          mem_lat = 0;
    bit          last_resp = 1'b0;
    bit          last_acc = 1'b0;
    logic [31:0] acc_addr = 32'h0;

    // Behavioural model state.
    logic [31:0] m_pc;
    logic        m_out;
    logic        m_kill;
    logic        m_held;
    logic [31:0] m_instr;
    logic [31:0] m_ipc;
    logic        exp_rv;

    instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk             (clk),
        .resetn          (resetn),
        .imem_req_valid  (imem_req_valid),
        .imem_req_addr   (imem_req_addr),
        .imem_req_ready  (imem_req_ready),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .instr_valid     (instr_valid),
        .instr           (instr),
        .instr_pc        (instr_pc),
        .instr_ready     (instr_ready),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_0000) return 32'h8C01_0004;
        return {a[15:0], ~a[15:0]};
    endfunction

    // Model: a request may issue only when nothing is outstanding or held;
    // a redirect retargets pc and poisons anything in flight or held.
    always @(posedge clk) begin
        if (!resetn) begin
            m_pc <= 32'h0; m_out <= 1'b0; m_kill <= 1'b0;
            m_held <= 1'b0; m_instr <= 32'h0; m_ipc <= 32'h0;
        end else if (m_held) begin
            if (redirect_valid) begin
                m_held <= 1'b0;
                m_pc   <= redirect_pc & 32'hFFFF_FFFC;
            end else if (instr_ready) begin
                m_held <= 1'b0;
            end
        end else if (m_out) begin
            if (imem_resp_valid) begin
                m_out  <= 1'b0;
                m_kill <= 1'b0;
                if (!m_kill && !redirect_valid) begin
                    m_held  <= 1'b1;
                    m_instr <= imem_resp_data;
                    m_ipc   <= m_pc;
                    m_pc    <= m_pc + 32'd4;
                end
            end else if (redirect_valid) begin
                m_kill <= 1'b1;
            end
            if (redirect_valid) m_pc <= redirect_pc & 32'hFFFF_FFFC;
        end else begin
            if (imem_req_ready) begin
                m_out  <= 1'b1;
                m_kill <= redirect_valid;
            end
            if (redirect_valid) m_pc <= redirect_pc & 32'hFFFF_FFFC;
        end
    end

    // Compare DUT against the model every cycle, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            exp_rv = !m_out && !m_held;
            n_checks++;
            if (imem_req_valid !== exp_rv) begin
                n_fail++;
                $display("FAIL model_req_valid t=%0t got %0b exp %0b", $time, imem_req_valid, exp_rv);
            end
            n_checks++;
            if (imem_req_addr !== m_pc) begin
                n_fail++;
                $display("FAIL model_req_addr t=%0t got %h exp %h", $time, imem_req_addr, m_pc);
            end
            n_checks++;
            if (instr_valid !== m_held) begin
                n_fail++;
                $display("FAIL model_instr_valid t=%0t got %0b exp %0b", $time, instr_valid, m_held);
            end
            if (m_held) begin
                n_checks++;
                if (instr !== m_instr || instr_pc !== m_ipc) begin
                    n_fail++;
                    $display("FAIL model_instr t=%0t got %h@%h exp %h@%h", $time, instr, instr_pc, m_instr, m_ipc);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got %h exp %h", nm, got, exp);
        end
    endtask

    // One clock cycle: update memory, drive inputs, return at the falling edge.
    task automatic cyc(input logic rst_i, input logic rdy, input logic irdy,
                       input logic rv, input logic [31:0] rpc);
        @(posedge clk); #1;
        if (last_resp) pend = 1'b0;
        else if (pend && dly > 0) dly--;
        if (last_acc) begin
            pend = 1'b1; paddr = acc_addr; dly = mem_lat;
        end
        resetn = rst_i; imem_req_ready = rdy; instr_ready = irdy;
        redirect_valid = rv; redirect_pc = rpc;
        imem_resp_valid = pend && (dly == 0);
        imem_resp_data  = imem_resp_valid ? mem_word(paddr) : 32'hDEAD_BEEF;
        last_resp = imem_resp_valid;
        @(negedge clk);
        last_acc = imem_req_valid && rdy && rst_i;
        acc_addr = imem_req_addr;
    endtask

    task automatic step(input logic rdy, input logic irdy);
        cyc(1'b1, rdy, irdy, 1'b0, 32'h0);
    endtask

    initial begin
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        chk_en = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("reset_req_valid", {31'b0, imem_req_valid}, 32'd1);
        chk("reset_req_addr", imem_req_addr, 32'h0000_0000);
        chk("reset_instr_valid", {31'b0, instr_valid}, 32'd0);

        // Zero-wait fetch of LW at address 0.
        step(1'b1, 1'b1);
        chk("c1_req_addr", imem_req_addr, 32'h0000_0000);
        step(1'b1, 1'b1);
        chk("c2_no_instr", {31'b0, instr_valid}, 32'd0);
        step(1'b1, 1'b1);
        chk("c3_instr_valid", {31'b0, instr_valid}, 32'd1);
        chk("c3_instr", instr, 32'h8C01_0004);
        chk("c3_instr_pc", instr_pc, 32'h0000_0000);

        // Memory not ready for 5 cycles.
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1);
            chk("stall_req_addr", imem_req_addr, 32'h0000_0004);
            chk("stall_req_valid", {31'b0, imem_req_valid}, 32'd1);
        end
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);

        // Decode not ready for 4 cycles.
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0);
            chk("hold_instr", instr, 32'h0004_FFFB);
            chk("hold_instr_pc", instr_pc, 32'h0000_0004);
            chk("hold_no_req", {31'b0, imem_req_valid}, 32'd0);
        end
        step(1'b1, 1'b1);

        // Redirect while waiting on a one-cycle-latency memory.
        mem_lat = 1;
        step(1'b1, 1'b1);
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0103);
        step(1'b1, 1'b1);
        chk("drop_no_instr", {31'b0, instr_valid}, 32'd0);
        chk("drop_no_req", {31'b0, imem_req_valid}, 32'd0);
        step(1'b1, 1'b1);
        chk("redir_req_addr", imem_req_addr, 32'h0000_0100);
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        mem_lat = 0;
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0200);
        chk("redir_hold_pc", instr_pc, 32'h0000_0100);

        // Redirect together with instr_ready in HOLD.
        step(1'b1, 1'b1);
        chk("hold_redir_no_instr", {31'b0, instr_valid}, 32'd0);
        chk("hold_redir_addr", imem_req_addr, 32'h0000_0200);
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        chk("tgt_instr_pc", instr_pc, 32'h0000_0200);

        // Wrap at the top of the address space.
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF);
        step(1'b1, 1'b1);
        chk("top_req_addr", imem_req_addr, 32'hFFFF_FFFC);
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        chk("top_instr_pc", instr_pc, 32'hFFFF_FFFC);
        mem_lat = 2;
        step(1'b1, 1'b1);
        chk("wrap_req_addr", imem_req_addr, 32'h0000_0000);

        // Reset while waiting; late response must be ignored.
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b1);
        chk("rst_wait_req_valid", {31'b0, imem_req_valid}, 32'd1);
        chk("rst_wait_addr", imem_req_addr, 32'h0000_0000);
        step(1'b0, 1'b1);
        chk("late_resp_no_instr", {31'b0, instr_valid}, 32'd0);
        chk("late_resp_req_valid", {31'b0, imem_req_valid}, 32'd1);
        mem_lat = 0;
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        chk("post_rst_instr", instr, 32'h8C01_0004);
        chk("post_rst_instr_pc", instr_pc, 32'h0000_0000);

        // Mixed traffic, checked by the model only.
        for (int i = 0; i < 300; i++) begin
            mem_lat = $urandom_range(0, 2);
            cyc(1'b1, ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
                ($urandom_range(0, 9) == 0), $urandom);
        end

        @(posedge clk); #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
